progmem_loader: RTL

Hardware responder for the host-side program download protocol. It receives framed bytes from the debug UART receiver and streams 16-bit words into the code RAM write port. It holds the target MCU during a download and answers each frame with a single ACK or NAK byte through the UART transmitter. It sits beside the supervisor, driving the same dual-port code RAM port A, so a target image can be loaded with no supervisor firmware involvement.

---
 rtl/progmem_loader_pkg.sv | 34 +++
 rtl/loader_timeout.sv | 48 ++++
 rtl/progmem_loader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/progmem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : progmem_loader_pkg
// Description : Shared types and constants for the program-download responder
//               (FSM state encoding, response bytes, default frame marker).
// Revision    : 1.0 - initial release
// ============================================================================
package progmem_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR_HI = 4'd1,
    ST_ADDR_LO = 4'd2,
    ST_CNT_HI  = 4'd3,
    ST_CNT_LO  = 4'd4,
    ST_DATA_HI = 4'd5,
    ST_DATA_LO = 4'd6,
    ST_CHK     = 4'd7,
    ST_RESP    = 4'd8
  } state_e;

  localparam logic [7:0] c_ACK          = 8'h06;
  localparam logic [7:0] c_NAK          = 8'h15;
  localparam logic [7:0] c_SYNC_DEFAULT = 8'hA5;

  // True while a frame is being received (inter-byte timeout is armed).
  function automatic logic in_frame(input state_e s);
    return (s == ST_ADDR_HI) || (s == ST_ADDR_LO) || (s == ST_CNT_HI) ||
           (s == ST_CNT_LO)  || (s == ST_DATA_HI) || (s == ST_DATA_LO) ||
           (s == ST_CHK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/loader_timeout.sv
`default_nettype none
// ============================================================================
// Module      : loader_timeout
// Description : Reloadable down-counter. Flags expiry after TIMEOUT_CYCLES
//               consecutive enabled cycles without a reload.
// Revision    : 1.0 - initial release
// ============================================================================
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic sysclk,
  input  logic sysreset,
  input  logic reload,
  input  logic enable,
  output logic expired
);

  // Counter holds TIMEOUT_CYCLES-1 after a reload; the cycle it reads zero
  // is the TIMEOUT_CYCLES-th quiet cycle.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] c_RELOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: reload wins, otherwise decrement while enabled and non-zero.
  always_comb begin
    count_d = count_q;
    if (reload) begin
      count_d = c_RELOAD;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && !reload && (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/progmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : progmem_loader
// Description : Host program-download responder. Parses framed UART bytes,
//               streams 16-bit words into the code RAM write port, holds the
//               target during a download and answers each frame with ACK/NAK.
// Revision    : 1.0 - initial release
// ============================================================================
module progmem_loader
  import progmem_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 10,
  parameter logic [7:0] SYNC_BYTE      = c_SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  sysclk,
  input  logic                  sysreset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data,
  output logic                  tx_load,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_data,
  output logic                  ram_wren,
  output logic                  tg_hold,
  output logic                  load_done,
  output logic                  load_error
);

  state_e                  state_q,      state_d;
  logic [7:0]              sum_q,        sum_d;
  logic [7:0]              hi_q,         hi_d;
  logic [ADDR_WIDTH-1:0]   addr_q,       addr_d;
  logic [15:0]             cnt_q,        cnt_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q,   ram_addr_d;
  logic [15:0]             ram_data_q,   ram_data_d;
  logic                    ram_wren_q,   ram_wren_d;
  logic                    tg_hold_q,    tg_hold_d;
  logic                    load_error_q, load_error_d;
  logic [7:0]              resp_q,       resp_d;

  logic                    w_expired;
  logic [7:0]              w_sum_next;
  logic [15:0]             w_word;
  logic [ADDR_WIDTH-1:0]   w_frame_addr;

  assign w_sum_next = sum_q + rx_data;
  assign w_word     = {hi_q, rx_data};

  // Frame address is 16 bits on the wire; keep only the RAM-sized low part.
  generate
    if (ADDR_WIDTH > 16) begin : g_addr_wide
      assign w_frame_addr = {{(ADDR_WIDTH-16){1'b0}}, hi_q, rx_data};
    end else if (ADDR_WIDTH > 8) begin : g_addr_mid
      assign w_frame_addr = {hi_q[ADDR_WIDTH-9:0], rx_data};
    end else begin : g_addr_narrow
      assign w_frame_addr = rx_data[ADDR_WIDTH-1:0];
    end
  endgenerate

  loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .sysclk   (sysclk),
    .sysreset (sysreset),
    .reload   (rx_valid),
    .enable   (in_frame(state_q)),
    .expired  (w_expired)
  );

  // Frame parser: next state, checksum, address/count tracking and RAM write.
  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    hi_d         = hi_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_wren_d   = 1'b0;
    tg_hold_d    = tg_hold_q;
    load_error_d = load_error_q;
    resp_d       = resp_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d   = ST_ADDR_HI;
          sum_d     = 8'h00;
          tg_hold_d = 1'b1;
        end
      end
      ST_ADDR_HI: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          sum_d   = w_sum_next;
          state_d = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (rx_valid) begin
          addr_d  = w_frame_addr;
          sum_d   = w_sum_next;
          state_d = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          sum_d   = w_sum_next;
          state_d = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (rx_valid) begin
          cnt_d   = w_word;
          sum_d   = w_sum_next;
          state_d = (w_word == 16'h0000) ? ST_CHK : ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          sum_d   = w_sum_next;
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (rx_valid) begin
          ram_wren_d = 1'b1;
          ram_addr_d = addr_q;
          ram_data_d = w_word;
          addr_d     = addr_q + 1'b1;
          cnt_d      = cnt_q - 1'b1;
          sum_d      = w_sum_next;
          state_d    = (cnt_q == 16'h0001) ? ST_CHK : ST_DATA_HI;
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          sum_d   = w_sum_next;
          state_d = ST_RESP;
          if (w_sum_next == 8'h00) begin
            resp_d       = c_ACK;
            load_error_d = 1'b0;
            tg_hold_d    = 1'b0;
          end else begin
            resp_d       = c_NAK;
            load_error_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A stalled host aborts the frame; expiry never coincides with rx_valid.
    if (w_expired) begin
      state_d      = ST_RESP;
      resp_d       = c_NAK;
      load_error_d = 1'b1;
    end
  end

  // State and datapath registers; reset aborts any frame silently.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state_q      <= ST_IDLE;
      sum_q        <= 8'h00;
      hi_q         <= 8'h00;
      addr_q       <= '0;
      cnt_q        <= 16'h0000;
      ram_addr_q   <= '0;
      ram_data_q   <= 16'h0000;
      ram_wren_q   <= 1'b0;
      tg_hold_q    <= 1'b0;
      load_error_q <= 1'b0;
      resp_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      hi_q         <= hi_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_wren_q   <= ram_wren_d;
      tg_hold_q    <= tg_hold_d;
      load_error_q <= load_error_d;
      resp_q       <= resp_d;
    end
  end

  // Response strobe is combinational so it fires the first idle-transmitter
  // cycle spent in RESP; tx_data is held in resp_q throughout.
  assign tx_load    = (state_q == ST_RESP) && !tx_busy;
  assign load_done  = tx_load && (resp_q == c_ACK);
  assign tx_data    = resp_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign ram_wren   = ram_wren_q;
  assign tg_hold    = tg_hold_q;
  assign load_error = load_error_q;

endmodule
`default_nettype wire
